// File: rtl/fb_mem_responder_if.sv
// Command/response bus of fb_mem_responder: two command queues in, two response queues out.
interface fb_mem_responder_if;
   logic [40:0]  writer_d_i;
   logic         writer_enq_i;
   logic         writer_full_o;
   logic [31:0]  writer_burst_d_i;
   logic         writer_burst_enq_i;
   logic         writer_burst_full_o;
   logic [15:0]  reader_q_o;
   logic         reader_deq_i;
   logic         reader_empty_o;
   logic [127:0] reader_burst_q_o;
   logic         reader_burst_deq_i;
   logic         reader_burst_empty_o;
   logic         reader_burst_alm_empty_o;
   logic         err_o;

   modport slave (
      input  writer_d_i, writer_enq_i, writer_burst_d_i, writer_burst_enq_i,
             reader_deq_i, reader_burst_deq_i,
      output writer_full_o, writer_burst_full_o, reader_q_o, reader_empty_o,
             reader_burst_q_o, reader_burst_empty_o, reader_burst_alm_empty_o, err_o
   );

   modport master (
      output writer_d_i, writer_enq_i, writer_burst_d_i, writer_burst_enq_i,
             reader_deq_i, reader_burst_deq_i,
      input  writer_full_o, writer_burst_full_o, reader_q_o, reader_empty_o,
             reader_burst_q_o, reader_burst_empty_o, reader_burst_alm_empty_o, err_o
   );
endinterface

// File: rtl/fb_mem_responder.sv
// On-chip 16-bit memory serving single read/write and 8-word burst-read commands via show-ahead FIFOs.
// Define FB_MEM_RESPONDER_ERR_EN to enable the sticky protocol-error flag on err_o.
module fb_mem_responder_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         enq,
   input  logic [W-1:0] d,
   output logic         full,
   input  logic         deq,
   output logic [W-1:0] q,
   output logic         empty,
   output logic         alm_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  store [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_enq, do_deq;

   always_comb begin
      empty     = (cnt_q == '0);
      full      = (cnt_q == CW'(DEPTH));
      alm_empty = (cnt_q <= CW'(1));
      do_enq    = enq && !full;
      do_deq    = deq && !empty;
      wr_ptr_d  = wr_ptr_q + AW'(do_enq);
      rd_ptr_d  = rd_ptr_q + AW'(do_deq);
      cnt_d     = cnt_q + CW'(do_enq) - CW'(do_deq);
      // Head reads as zero while empty so q is clean straight out of reset.
      q         = empty ? '0 : store[rd_ptr_q];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_enq) store[wr_ptr_q] <= d;
   end
endmodule

module fb_mem_responder #(
   parameter int MEM_WORDS  = 16384,
   parameter int CMD_DEPTH  = 4,
   parameter int RESP_DEPTH = 4
) (
   input  logic              clk_pix,
   input  logic              reset_n_i,
   fb_mem_responder_if.slave bus
);
   localparam int AW = $clog2(MEM_WORDS);

   typedef enum logic [1:0] {IDLE, SINGLE_RD, BURST_RD} state_t;

   state_t         state_q, state_d;
   logic [2:0]     beat_q, beat_d;
   logic [AW-1:0]  base_q, base_d;
   logic [111:0]   pack_q, pack_d;
   logic [15:0]    rd_data_q;
   logic [15:0]    mem [MEM_WORDS];

   logic [40:0]    scmd_q;
   logic [31:0]    bcmd_q;
   logic           scmd_empty, scmd_full, scmd_alm, scmd_pop;
   logic           bcmd_empty, bcmd_full, bcmd_alm, bcmd_pop;
   logic           sresp_empty, sresp_full, sresp_alm, sresp_push;
   logic           bresp_empty, bresp_full, bresp_push;
   logic           mem_en, mem_we;
   logic [AW-1:0]  mem_addr;
   logic           unused_bits;

   fb_mem_responder_fifo #(.W(41), .DEPTH(CMD_DEPTH)) u_scmd (
      .clk(clk_pix), .rst_n(reset_n_i), .enq(bus.writer_enq_i), .d(bus.writer_d_i),
      .full(scmd_full), .deq(scmd_pop), .q(scmd_q), .empty(scmd_empty), .alm_empty(scmd_alm));

   fb_mem_responder_fifo #(.W(32), .DEPTH(CMD_DEPTH)) u_bcmd (
      .clk(clk_pix), .rst_n(reset_n_i), .enq(bus.writer_burst_enq_i), .d(bus.writer_burst_d_i),
      .full(bcmd_full), .deq(bcmd_pop), .q(bcmd_q), .empty(bcmd_empty), .alm_empty(bcmd_alm));

   fb_mem_responder_fifo #(.W(16), .DEPTH(RESP_DEPTH)) u_sresp (
      .clk(clk_pix), .rst_n(reset_n_i), .enq(sresp_push), .d(rd_data_q),
      .full(sresp_full), .deq(bus.reader_deq_i), .q(bus.reader_q_o), .empty(sresp_empty),
      .alm_empty(sresp_alm));

   fb_mem_responder_fifo #(.W(128), .DEPTH(RESP_DEPTH)) u_bresp (
      .clk(clk_pix), .rst_n(reset_n_i), .enq(bresp_push), .d({pack_q, rd_data_q}),
      .full(bresp_full), .deq(bus.reader_burst_deq_i), .q(bus.reader_burst_q_o),
      .empty(bresp_empty), .alm_empty(bus.reader_burst_alm_empty_o));

   assign bus.writer_full_o        = scmd_full;
   assign bus.writer_burst_full_o  = bcmd_full;
   assign bus.reader_empty_o       = sresp_empty;
   assign bus.reader_burst_empty_o = bresp_empty;
   // Address bits above the memory index and the burst pad byte are don't-care.
   assign unused_bits = ^{scmd_q, bcmd_q, scmd_alm, bcmd_alm, sresp_alm};

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      base_d     = base_q;
      pack_d     = pack_q;
      scmd_pop   = 1'b0;
      bcmd_pop   = 1'b0;
      sresp_push = 1'b0;
      bresp_push = 1'b0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = scmd_q[16 +: AW];
      unique case (state_q)
         IDLE: begin
            // Response space is reserved before a read command leaves its FIFO.
            if (!bcmd_empty && !bresp_full) begin
               bcmd_pop = 1'b1;
               mem_en   = 1'b1;
               mem_addr = bcmd_q[AW-1:0];
               base_d   = bcmd_q[AW-1:0];
               beat_d   = 3'd0;
               state_d  = BURST_RD;
            end else if (!scmd_empty) begin
               if (scmd_q[40]) begin
                  scmd_pop = 1'b1;
                  mem_en   = 1'b1;
                  mem_we   = 1'b1;
               end else if (!sresp_full) begin
                  scmd_pop = 1'b1;
                  mem_en   = 1'b1;
                  state_d  = SINGLE_RD;
               end
            end
         end
         SINGLE_RD: begin
            sresp_push = 1'b1;
            state_d    = IDLE;
         end
         BURST_RD: begin
            // beat_q counts words already returned; the next address is issued one ahead.
            pack_d = {pack_q[95:0], rd_data_q};
            if (beat_q == 3'd7) begin
               bresp_push = 1'b1;
               state_d    = IDLE;
            end else begin
               mem_en   = 1'b1;
               mem_addr = base_q + AW'(beat_q) + AW'(1);
               beat_d   = beat_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_pix or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         beat_q  <= 3'd0;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         base_q  <= base_d;
      end
   end

   always_ff @(posedge clk_pix) begin
      pack_q <= pack_d;
   end

   // Single-port memory: either a write or a registered read each cycle.
   always_ff @(posedge clk_pix) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= scmd_q[15:0];
         else        rd_data_q     <= mem[mem_addr];
      end
   end

`ifdef FB_MEM_RESPONDER_ERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q
            | (bus.writer_enq_i       & scmd_full)
            | (bus.writer_burst_enq_i & bcmd_full)
            | (bus.reader_deq_i       & sresp_empty)
            | (bus.reader_burst_deq_i & bresp_empty);
   end

   always_ff @(posedge clk_pix or negedge reset_n_i) begin
      if (!reset_n_i) err_q <= 1'b0;
      else            err_q <= err_d;
   end

   assign bus.err_o = err_q;
`else
   assign bus.err_o = 1'b0;
`endif
endmodule
